hdc_main: RTL and testbench
===========================

# hdc_main

Hyperdimensional-computing (HDC) SMS classifier: takes a message of up to 200 8-bit characters and labels it ham or spam. It encodes character trigrams into a binary hypervector, bundles them by per-bit majority, and picks the nearer class hypervector by Hamming distance. It is the top-level compute block; a testbench drives a message, its length and its true tag, then samples `result`.

## Interface
- `DIM`, 256: hypervector width in bits; a multiple of 32.
- `MSG_LEN`, 200: maximum number of characters.
- `CHAR_W`, 8: bits per character.
- `clk`  in  1: the single clock.
- `reset`  in  1: synchronous, active-high.
- `msg`  in  CHAR_W*MSG_LEN: character p is `msg[8p+:8]`; character 0 is at the LSBs.
- `length`  in  8: number of valid characters.
- `label`  in  2: true tag (00 ham, 01 spam). Used only with `HDC_TRAIN_EN`.
- `result`  out  2: 00 ham, 01 spam, 11 inconclusive or busy. The value 10 is never driven.

## Operation
- **Item memory.** IM(c) for character code c is the concatenation of DIM/32 words. Word i = xs(c ^ (i<<8) ^ 32'h9E3779B9).
  - xs(x): x ^= x<<13; x ^= x>>17; x ^= x<<5 (32-bit).
  - Computed combinationally; no ROM.
- **Trigram.** g_p = rho²(IM(c_p)) ^ rho(IM(c_{p+1})) ^ IM(c_{p+2}), where rho is a 1-bit rotate left. One trigram per p = 0..length-3.
- **Bundling.** DIM per-bit 8-bit counters count the ones across all trigrams. Query bit = 1 iff 2·count > n, where n = length-2. A tie gives 0.
- **Class vectors.** HAM_HV words = xs(32'h48414D00 ^ i); SPAM_HV words = xs(32'h5350414D ^ i).
- **Decision.** Compute d_h = popcount(q ^ HAM_HV) and d_s = popcount(q ^ SPAM_HV).
  - d_h < d_s gives 00; d_s < d_h gives 01; equal gives 11.
- **Invalid length.** length < 3 or length > MSG_LEN gives 11 without encoding.
- **Start condition.** A new computation starts when the FSM is in IDLE and either:
  - {msg, length} differs from the latched copy, or
  - the pending-after-reset flag is set.
- **Latching.** Inputs are latched at start. Input changes during a computation are ignored; they retrigger a computation after DONE.
- **FSM transitions:**
  - IDLE → ENCODE on start. Go directly to DONE if the length is invalid.
  - ENCODE runs n cycles, one trigram per cycle, then → THRESH.
  - THRESH (form query) → COMPARE (register both distances) → DONE.
  - DONE writes `result` → IDLE.

## Timing
- **Reset values:**
  - `result` = 11, state = IDLE.
  - Counters and latched copy = 0.
  - Pending-after-reset flag = 1.
- **Busy indication.** `result` is driven to 11 on the edge leaving IDLE and holds until DONE.
- **Latency.** The result is valid on the edge ending DONE, n+3 cycles after leaving IDLE. For an invalid length it is 1 cycle. Maximum is 201 cycles.
- **Result stability.** `result` holds steady while inputs are unchanged.
- **Reset mid-operation.** Aborts the computation and returns to the reset state; the message is then recomputed from scratch.
- **Counters.** Cleared on entering ENCODE; they cannot overflow because n ≤ 198.

## Configuration
- **`HDC_TRAIN_EN` defined:**
  - Each class has DIM signed 8-bit counters. They are initialised at reset to +1 where the constant bit is 1 and -1 where it is 0.
  - Each class vector bit = (counter > 0).
  - In DONE, if the latched label is 00 or 01 and the result was not 11 due to invalid length, that class's counters add +1 for each query bit 1 and -1 for each query bit 0, saturating at ±127.
  - The update takes effect for the next message.
- **`HDC_TRAIN_EN` undefined:**
  - Class vectors are the fixed constants.
  - `label` is unused; tie it off without a lint warning.

## Structure
- **Package `hdc_pkg`:**
  - Constants DIM, MSG_LEN, CHAR_W.
  - Result encodings RES_HAM/RES_SPAM/RES_INC.
  - FSM state enum.
  - xs() and item_hv() functions.
  - HAM_HV and SPAM_HV constants.
- **Sub-module `hdc_popcount`:** a DIM-bit combinational popcount, instantiated twice.

## Test plan
- Reset asserted for 2 cycles → `result`=11. After release, a computation runs on the current inputs and completes within 201 cycles.
- length=0 and length=201 → `result`=11 two cycles after start.
- msg = 50 × 'a' (8'h61), length=50 → result matches the package golden model after 51 cycles and is stable for 1000 further cycles.
- Change msg mid-ENCODE → first result computed from the old message, then a new computation starts automatically and yields the golden result for the new msg.
- Assert reset during ENCODE → `result`=11, recomputation, same golden result as an uninterrupted run.
- With `HDC_TRAIN_EN`: present the same length-100 message 20 times with label=01 → its result converges to 01 and stays there.

Source files
------------

// File: rtl/hdc_pkg.sv
// Purpose : shared constants, FSM state type, hash helpers and class hypervectors
//           for the HDC ham/spam classifier.
// Contents: DIM/MSG_LEN/CHAR_W, RES_* encodings, state_t, xs(), item_hv(), HAM_HV, SPAM_HV.
package hdc_pkg;

  localparam int DIM     = 256;
  localparam int MSG_LEN = 200;
  localparam int CHAR_W  = 8;
  localparam int NWORDS  = DIM / 32;
  localparam int CNT_W   = 8;
  localparam int DIST_W  = $clog2(DIM + 1);

  localparam logic [1:0] RES_HAM  = 2'b00;
  localparam logic [1:0] RES_SPAM = 2'b01;
  localparam logic [1:0] RES_INC  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENCODE,
    ST_THRESH,
    ST_COMPARE,
    ST_DONE
  } state_t;

  typedef logic [DIM-1:0] hv_t;

  // 32-bit xorshift used to synthesise all pseudo-random hypervectors.
  function automatic logic [31:0] xs(input logic [31:0] x_in);
    logic [31:0] x;
    x = x_in;
    x = x ^ (x << 13);
    x = x ^ (x >> 17);
    x = x ^ (x << 5);
    return x;
  endfunction

  // Item memory: word i of IM(c) occupies bits [32*i +: 32].
  function automatic hv_t item_hv(input logic [CHAR_W-1:0] c);
    hv_t hv;
    for (int i = 0; i < NWORDS; i++) begin
      hv[32*i +: 32] = xs(32'(c) ^ (32'(i) << 8) ^ 32'h9E3779B9);
    end
    return hv;
  endfunction

  function automatic hv_t class_hv(input logic [31:0] seed);
    hv_t hv;
    for (int i = 0; i < NWORDS; i++) begin
      hv[32*i +: 32] = xs(seed ^ 32'(i));
    end
    return hv;
  endfunction

  function automatic hv_t rotl1(input hv_t v);
    return {v[DIM-2:0], v[DIM-1]};
  endfunction

  localparam hv_t HAM_HV  = class_hv(32'h48414D00);
  localparam hv_t SPAM_HV = class_hv(32'h5350414D);

endpackage

// File: rtl/hdc_if.sv
// Purpose : message/result bundle between the classifier and its driver.
// Ports   : msg (CHAR_W*MSG_LEN, char 0 at LSBs), length (8), label (2) towards the
//           classifier; result (2) back from it. master = driver, slave = classifier.
interface hdc_if;
  import hdc_pkg::*;

  logic [CHAR_W*MSG_LEN-1:0] msg;
  logic [7:0]                length;
  logic [1:0]                label;
  logic [1:0]                result;

  modport master (output msg, output length, output label, input result);
  modport slave  (input msg, input length, input label, output result);

endinterface

// File: rtl/hdc_popcount.sv
// Purpose : combinational population count of a W-bit vector.
// Latency : 0 cycles (pure combinational).
// Ports   : i_vec (W) in, o_cnt ($clog2(W+1)) out; no flow control.
module hdc_popcount
  import hdc_pkg::*;
#(
  parameter int W  = DIM,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_vec,
  output logic [CW-1:0] o_cnt
);

  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < W; i++) begin
      o_cnt = o_cnt + CW'(i_vec[i]);
    end
  end

endmodule

// File: rtl/hdc_main.sv
// Purpose : HDC SMS classifier - trigram encode, majority bundle, nearest class by Hamming.
// Latency : result n+3 cycles after leaving IDLE (n = length-2), 1 cycle for an invalid length.
// Flow    : no backpressure; input changes mid-computation are picked up after DONE.
// Ports   : clk, reset (sync, active-high), bus (hdc_if.slave: msg, length, label -> result).
// Option  : HDC_TRAIN_EN enables on-line class-vector training from bus.label.
module hdc_main
  import hdc_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  hdc_if.slave  bus
);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [CHAR_W*MSG_LEN-1:0] r_msg;
  logic [7:0]                r_len;
  logic                      r_pending;
  logic                      r_invalid;
  logic [7:0]                r_pos;
  logic [CNT_W-1:0]          r_cnt [DIM];
  hv_t                       r_query;
  logic [DIST_W-1:0]         r_dh;
  logic [DIST_W-1:0]         r_ds;
  logic [1:0]                r_result;

  logic                      w_trigger;
  logic                      w_len_ok;
  logic [7:0]                w_n;
  logic                      w_start;
  logic                      w_accum;
  logic                      w_thresh;
  logic                      w_cmp;
  logic                      w_done;
  logic [7:0]                w_p1;
  logic [7:0]                w_p2;
  logic [CHAR_W-1:0]         w_c0;
  logic [CHAR_W-1:0]         w_c1;
  logic [CHAR_W-1:0]         w_c2;
  hv_t                       w_tri;
  hv_t                       w_ham_hv;
  hv_t                       w_spam_hv;
  logic [DIST_W-1:0]         w_dh;
  logic [DIST_W-1:0]         w_ds;

  // Any difference from the latched copy (or the post-reset flag) retriggers.
  assign w_trigger = ({bus.msg, bus.length} != {r_msg, r_len}) || r_pending;
  assign w_len_ok  = (bus.length >= 8'd3) && (bus.length <= 8'(MSG_LEN));
  assign w_n       = r_len - 8'd2;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_trigger) w_state_nxt = w_len_ok ? ST_ENCODE : ST_DONE;
      ST_ENCODE:  if (r_pos == w_n - 8'd1) w_state_nxt = ST_THRESH;
      ST_THRESH:  w_state_nxt = ST_COMPARE;
      ST_COMPARE: w_state_nxt = ST_DONE;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs (datapath strobes) ----------------
  always_comb begin
    w_start  = 1'b0;
    w_accum  = 1'b0;
    w_thresh = 1'b0;
    w_cmp    = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      ST_IDLE:    w_start  = w_trigger;
      ST_ENCODE:  w_accum  = 1'b1;
      ST_THRESH:  w_thresh = 1'b1;
      ST_COMPARE: w_cmp    = 1'b1;
      ST_DONE:    w_done   = 1'b1;
      default:    w_start  = 1'b0;
    endcase
  end

  // ---------------- trigram encoder ----------------
  assign w_p1  = r_pos + 8'd1;
  assign w_p2  = r_pos + 8'd2;
  assign w_c0  = r_msg[int'(r_pos) * CHAR_W +: CHAR_W];
  assign w_c1  = r_msg[int'(w_p1)  * CHAR_W +: CHAR_W];
  assign w_c2  = r_msg[int'(w_p2)  * CHAR_W +: CHAR_W];
  assign w_tri = rotl1(rotl1(item_hv(w_c0))) ^ rotl1(item_hv(w_c1)) ^ item_hv(w_c2);

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_msg     <= '0;
      r_len     <= '0;
      r_pending <= 1'b1;
      r_invalid <= 1'b0;
      r_pos     <= '0;
      r_query   <= '0;
      r_dh      <= '0;
      r_ds      <= '0;
      r_result  <= RES_INC;
      for (int b = 0; b < DIM; b++) r_cnt[b] <= '0;
    end else begin
      if (w_start) begin
        r_msg     <= bus.msg;
        r_len     <= bus.length;
        r_pending <= 1'b0;
        r_invalid <= !w_len_ok;
        r_pos     <= '0;
        r_result  <= RES_INC;
        for (int b = 0; b < DIM; b++) r_cnt[b] <= '0;
      end
      if (w_accum) begin
        r_pos <= w_p1;
        for (int b = 0; b < DIM; b++) r_cnt[b] <= r_cnt[b] + CNT_W'(w_tri[b]);
      end
      if (w_thresh) begin
        // Strict majority: a tie (2*count == n) yields 0.
        for (int b = 0; b < DIM; b++) r_query[b] <= ({r_cnt[b], 1'b0} > {1'b0, w_n});
      end
      if (w_cmp) begin
        r_dh <= w_dh;
        r_ds <= w_ds;
      end
      if (w_done) begin
        if (r_invalid)         r_result <= RES_INC;
        else if (r_dh < r_ds)  r_result <= RES_HAM;
        else if (r_ds < r_dh)  r_result <= RES_SPAM;
        else                   r_result <= RES_INC;
      end
    end
  end

  assign bus.result = r_result;

  // ---------------- class vectors ----------------
`ifdef HDC_TRAIN_EN
  logic              [1:0] r_label;
  logic signed [CNT_W-1:0] r_ham_acc  [DIM];
  logic signed [CNT_W-1:0] r_spam_acc [DIM];

  // One saturating step towards the query bit, clamped to +/-127.
  function automatic logic signed [CNT_W-1:0] acc_step(input logic signed [CNT_W-1:0] a,
                                                       input logic q);
    if (q && (a != 8'sd127))       return a + 8'sd1;
    else if (!q && (a != -8'sd127)) return a - 8'sd1;
    else                            return a;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_label <= '0;
      for (int b = 0; b < DIM; b++) begin
        r_ham_acc[b]  <= HAM_HV[b]  ? 8'sd1 : -8'sd1;
        r_spam_acc[b] <= SPAM_HV[b] ? 8'sd1 : -8'sd1;
      end
    end else begin
      if (w_start) r_label <= bus.label;
      // Distances were captured in COMPARE, so updating here only affects later messages.
      if (w_done && !r_invalid) begin
        for (int b = 0; b < DIM; b++) begin
          if (r_label == RES_HAM)  r_ham_acc[b]  <= acc_step(r_ham_acc[b],  r_query[b]);
          if (r_label == RES_SPAM) r_spam_acc[b] <= acc_step(r_spam_acc[b], r_query[b]);
        end
      end
    end
  end

  always_comb begin
    w_ham_hv  = '0;
    w_spam_hv = '0;
    for (int b = 0; b < DIM; b++) begin
      w_ham_hv[b]  = (r_ham_acc[b]  > 8'sd0);
      w_spam_hv[b] = (r_spam_acc[b] > 8'sd0);
    end
  end
`else
  logic w_unused_label;
  assign w_unused_label = ^bus.label;
  assign w_ham_hv       = HAM_HV;
  assign w_spam_hv      = SPAM_HV;
`endif

  hdc_popcount #(.W(DIM)) u_pc_ham (
    .i_vec (r_query ^ w_ham_hv),
    .o_cnt (w_dh)
  );

  hdc_popcount #(.W(DIM)) u_pc_spam (
    .i_vec (r_query ^ w_spam_hv),
    .o_cnt (w_ds)
  );

endmodule

// File: tb/tb_hdc_main.sv
// Purpose : self-checking bench for hdc_main; an independent bit-level golden model
//           fills a scoreboard queue at stimulus time, entries are popped when the result lands.
// Ports   : instantiates hdc_if and hdc_main; HDC_TRAIN_EN adds a training convergence run.
module tb_hdc_main;

  localparam int D  = 256;
  localparam int ML = 200;
  localparam int MW = 8 * ML;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hdc_if bus ();

  hdc_main dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [1:0] exp_q [$];

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: result=%b expected=%b", tag, got, exp);
  endtask

  // ---------------- golden model ----------------
  function automatic logic [31:0] mix(input logic [31:0] x_in);
    logic [31:0] x;
    x = x_in;
    x = x ^ (x << 13);
    x = x ^ (x >> 17);
    x = x ^ (x << 5);
    return x;
  endfunction

  function automatic bit im_bit(input logic [7:0] c, input int b);
    logic [31:0] w;
    w = mix({24'h0, c} ^ (32'(b / 32) << 8) ^ 32'h9E3779B9);
    return w[b % 32];
  endfunction

  function automatic bit cls_bit(input logic [31:0] seed, input int b);
    logic [31:0] w;
    w = mix(seed ^ 32'(b / 32));
    return w[b % 32];
  endfunction

  function automatic logic [1:0] gold(input logic [MW-1:0] m, input int len);
    int n, cnt, dh, ds;
    logic [7:0] c0, c1, c2;
    bit q;
    if (len < 3 || len > ML) return 2'b11;
    n  = len - 2;
    dh = 0;
    ds = 0;
    for (int b = 0; b < D; b++) begin
      cnt = 0;
      for (int p = 0; p < n; p++) begin
        c0 = m[8*p +: 8];
        c1 = m[8*(p+1) +: 8];
        c2 = m[8*(p+2) +: 8];
        // bit b of rot^k(v) is bit (b-k) mod D of v
        cnt += int'(im_bit(c0, (b + D - 2) % D) ^ im_bit(c1, (b + D - 1) % D) ^ im_bit(c2, b));
      end
      q = (2 * cnt > n);
      if (q != cls_bit(32'h48414D00, b)) dh++;
      if (q != cls_bit(32'h5350414D, b)) ds++;
    end
    if (dh < ds) return 2'b00;
    if (ds < dh) return 2'b01;
    return 2'b11;
  endfunction

  function automatic logic [MW-1:0] rand_msg();
    logic [MW-1:0] m;
    for (int i = 0; i < ML; i++) m[8*i +: 8] = 8'($urandom_range(32, 126));
    return m;
  endfunction

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic present(input logic [MW-1:0] m, input int len, input logic [1:0] lab);
    bus.msg    = m;
    bus.length = 8'(len);
    bus.label  = lab;
    exp_q.push_back(gold(m, len));
  endtask

  function automatic int lat_of(input int len);
    return (len < 3 || len > ML) ? 1 : len + 1;
  endfunction

  // Called at the negedge just before the edge that leaves IDLE.
  task automatic await_result(input string tag, input int lat);
    repeat (lat) @(negedge clk);
    chk({tag, "_busy"}, bus.result, 2'b11);
    @(negedge clk);
    if (exp_q.size() == 0) chk({tag, "_noexp"}, bus.result, 2'bxx);
    else                   chk(tag, bus.result, exp_q.pop_front());
  endtask

  logic [MW-1:0] m_a, m_x;
  logic [1:0]    g_a, bad;
  int            len_a, len_b;

  initial begin
    // ---- reset with a 50 x 'a' message already applied ----
    m_a = '0;
    for (int i = 0; i < 50; i++) m_a[8*i +: 8] = 8'h61;
    g_a   = gold(m_a, 50);
    reset = 1'b1;
    present(m_a, 50, 2'b10);
    repeat (2) @(negedge clk);
    chk("reset", bus.result, 2'b11);
    reset = 1'b0;
    await_result("a50", 51);

    // ---- stability with unchanged inputs ----
    bad = g_a;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.result !== g_a) bad = bus.result;
    end
    chk("a50_stable", bad, g_a);

    // ---- invalid / boundary lengths ----
    present(m_a, 0, 2'b10);   await_result("len0", 1);
    present(m_a, 201, 2'b10); await_result("len201", 1);
    present(m_a, 2, 2'b10);   await_result("len2", 1);
    present(m_a, 255, 2'b10); await_result("len255", 1);
    m_x = rand_msg();
    present(m_x, 3, 2'b10);   await_result("len3", lat_of(3));
    m_x = rand_msg();
    present(m_x, 200, 2'b10); await_result("len200", lat_of(200));

    // ---- random messages ----
    for (int k = 0; k < 4; k++) begin
      m_x   = rand_msg();
      len_a = $urandom_range(3, ML);
      present(m_x, len_a, 2'b10);
      await_result($sformatf("rnd%0d", k), lat_of(len_a));
    end

    // ---- message change mid-ENCODE ----
    len_a = 60;
    len_b = 40;
    present(rand_msg(), len_a, 2'b10);
    repeat (10) @(negedge clk);
    present(rand_msg(), len_b, 2'b10);
    repeat (lat_of(len_a) - 10) @(negedge clk);
    chk("midA_busy", bus.result, 2'b11);
    @(negedge clk);
    chk("midA", bus.result, exp_q.pop_front());
    await_result("midB", lat_of(len_b));

    // ---- reset during ENCODE ----
    present(rand_msg(), 80, 2'b10);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mid", bus.result, 2'b11);
    reset = 1'b0;
    await_result("rst_recalc", lat_of(80));

`ifdef HDC_TRAIN_EN
    // ---- training: same message, label spam, separated by invalid-length gaps ----
    m_x = rand_msg();
    for (int k = 0; k < 20; k++) begin
      bus.msg    = m_x;
      bus.length = 8'd100;
      bus.label  = 2'b01;
      if (k < 2) begin
        repeat (lat_of(100) + 1) @(negedge clk);
      end else begin
        exp_q.push_back(2'b01);
        await_result($sformatf("train%0d", k), lat_of(100));
      end
      present(m_x, 2, 2'b01);
      await_result($sformatf("train_gap%0d", k), 1);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
